// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 serial receiver that packs four bytes into a 32-bit
// little-endian word.
//   div_clk    : sampling clock, OVERSAMPLE x baud
//   reset      : synchronous, active-high
//   rx         : asynchronous serial line, idle high
//   data       : last completed word; first byte in [7:0]
//   data_valid : one-cycle pulse when data is updated
//   frame_err  : one-cycle pulse on a low stop bit
//   busy       : byte in progress or partial word held
module uart_word_rx #(
    parameter int OVERSAMPLE   = 16,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        div_clk,
    input  logic        reset,
    input  logic        rx,
    output logic [31:0] data,
    output logic        data_valid,
    output logic        frame_err,
    output logic        busy
);
    localparam int TW       = $clog2(OVERSAMPLE);
    localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
    localparam int CW       = $clog2(TO_LIMIT + 1);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] TO_END   = CW'(TO_LIMIT);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rxs_q, rxs_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bitn_q, bitn_d;
    logic [1:0]      byten_q, byten_d;
    logic [CW-1:0]   to_q, to_d;
    logic [7:0]      shift_q, shift_d;
    logic [23:0]     word_q, word_d;
    logic [31:0]     data_q, data_d;
    logic            data_valid_q, data_valid_d;
    logic            frame_err_q, frame_err_d;

    always_ff @(posedge div_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            tick_q       <= '0;
            bitn_q       <= '0;
            byten_q      <= '0;
            to_q         <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rxs_q        <= rxs_d;
            tick_q       <= tick_d;
            bitn_q       <= bitn_d;
            byten_q      <= byten_d;
            to_q         <= to_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        rx_meta_d    = rx;
        rxs_d        = rx_meta_q;
        state_d      = state_q;
        tick_d       = tick_q;
        bitn_d       = bitn_q;
        byten_d      = byten_q;
        to_d         = '0;     // timeout only accumulates while idling with a partial word
        shift_d      = shift_q;
        word_d       = word_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (!rxs_q) begin
                    state_d = S_START;
                end else if (byten_q != 2'd0) begin
                    to_d = to_q + 1'b1;
                    if (to_d == TO_END) begin
                        byten_d = '0;
                        to_d    = '0;
                    end
                end
            end
            S_START: begin
                tick_d = tick_q + 1'b1;
                if (tick_q == TICK_MID) begin
                    tick_d = '0;
                    if (!rxs_q) begin
                        bitn_d  = '0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;   // glitch: keep any partial word
                    end
                end
            end
            S_DATA: begin
                tick_d = tick_q + 1'b1;
                if (tick_q == TICK_END) begin
                    tick_d  = '0;
                    shift_d = {rxs_q, shift_q[7:1]};  // LSB arrives first
                    bitn_d  = bitn_q + 1'b1;
                    if (bitn_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                tick_d = tick_q + 1'b1;
                if (tick_q == TICK_END) begin
                    tick_d = '0;
                    if (rxs_q) begin
                        case (byten_q)
                            2'd0: word_d[7:0]   = shift_q;
                            2'd1: word_d[15:8]  = shift_q;
                            2'd2: word_d[23:16] = shift_q;
                            2'd3: begin
                                data_d       = {shift_q, word_q};
                                data_valid_d = 1'b1;
                            end
                        endcase
                        byten_d = byten_q + 1'b1;     // 3 wraps to 0
                        state_d = S_IDLE;             // leaves at mid stop bit
                    end else begin
                        frame_err_d = 1'b1;
                        byten_d     = '0;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                tick_d = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != S_IDLE) || (byten_q != 2'd0);
endmodule

// File: tb/tb_uart_word_rx.sv
module tb_uart_word_rx;
    localparam int OS = 16;
    localparam int TOB = 40;

    logic        div_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        rx      = 1'b1;
    logic [31:0] data;
    logic        data_valid, frame_err, busy;

    uart_word_rx #(.OVERSAMPLE(OS), .TIMEOUT_BITS(TOB)) dut (
        .div_clk(div_clk), .reset(reset), .rx(rx),
        .data(data), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 div_clk = ~div_clk;

    int n_chk = 0, n_err = 0;

    // Reference model: bytes accumulate into a word; errors/timeouts/reset drop it.
    logic [31:0] acc;
    int          cnt = 0;
    logic [31:0] exp_q[$];
    int          exp_fe = 0;
    logic [31:0] exp_last = 32'h0;

    // Observed outputs
    logic [31:0] got_q[$];
    int          fe_seen = 0, both_seen = 0;

    always @(negedge div_clk) begin
        if (data_valid) got_q.push_back(data);
        if (frame_err) fe_seen++;
        if (data_valid && frame_err) both_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic b, input int cycles);
        rx = b;
        repeat (cycles) @(negedge div_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        drive(1'b0, OS);
        for (int i = 0; i < 8; i++) drive(b[i], OS);
        drive(stop_ok, OS);
        if (stop_ok) begin
            if (cnt == 0) acc = 32'h0;
            acc[8*cnt +: 8] = b;
            cnt++;
            if (cnt == 4) begin
                exp_q.push_back(acc);
                exp_last = acc;
                cnt = 0;
            end
        end else begin
            cnt = 0;
            exp_fe++;
            drive(1'b1, 2*OS);
        end
    endtask

    // Gaps are kept either well under or past the timeout window.
    task automatic idle_bits(input int n);
        drive(1'b1, n*OS);
        if (n > TOB) cnt = 0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], 1'b1);
            if (gap > 0) idle_bits(gap);
        end
    endtask

    task automatic check_results(input string tag);
        int n;
        drive(1'b1, 2*OS);
        chk({tag, "_nwords"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_word"}, got_q[i], exp_q[i]);
        chk({tag, "_frame_err"}, fe_seen, exp_fe);
        chk({tag, "_dv_fe_overlap"}, both_seen, 0);
        chk({tag, "_busy"}, busy, (cnt != 0));
        got_q.delete(); exp_q.delete();
        fe_seen = 0; exp_fe = 0; both_seen = 0;
    endtask

    initial begin
        repeat (3) @(negedge div_clk);
        chk("rst_data", data, 32'h0);
        chk("rst_dv", data_valid, 1'b0);
        chk("rst_fe", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        drive(1'b1, 2*OS);

        send_word(32'h00000001, 0);
        check_results("word1");

        send_word(32'hDEADBEEF, 3);
        check_results("deadbeef");

        send_byte(8'h55, 1'b0);
        send_word(32'h00000002, 0);
        check_results("framing");

        send_byte(8'h11, 1'b1);
        drive(1'b0, 5);
        drive(1'b1, OS);
        chk("glitch_busy", busy, 1'b1);
        chk("glitch_no_pulse", fe_seen + got_q.size(), 0);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        chk("glitch_word", data, 32'h44332211);
        check_results("glitch");

        send_byte(8'hAA, 1'b1);
        idle_bits(41);
        chk("timeout_busy", busy, 1'b0);
        send_word(32'h00000003, 0);
        check_results("timeout");

        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        drive(1'b0, OS);
        for (int i = 0; i < 4; i++) drive(1'b0, OS);
        reset = 1'b1;
        rx = 1'b1;
        @(negedge div_clk);
        chk("midrst_data", data, 32'h0);
        chk("midrst_dv", data_valid, 1'b0);
        chk("midrst_fe", frame_err, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        repeat (2) @(negedge div_clk);
        reset = 1'b0;
        cnt = 0;
        exp_last = 32'h0;
        drive(1'b1, 2*OS);
        send_word(32'h00000004, 0);
        check_results("midrst");

        for (int w = 0; w < 16; w++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(8'($urandom), $urandom_range(0, 11) != 0);
                if ($urandom_range(0, 9) == 0) idle_bits(45);
                else idle_bits($urandom_range(0, 3));
            end
        end
        check_results("random");
        chk("data_hold", data, exp_last);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Serial receive front end of the CPU communication path. Oversamples the asynchronous `rx` line on `div_clk`, which runs at 16× the baud rate. Recovers 8N1 bytes and packs four consecutive bytes into a 32-bit little-endian word. It presents each completed word to the command controller with a single-cycle `data_valid` strobe. It also discards partial words on framing errors or inter-byte timeouts.

## Interface
- `OVERSAMPLE`, default 16: `div_clk` cycles per bit; must be even and ≥ 4.
- `TIMEOUT_BITS`, default 40: bit periods of idle line tolerated between bytes of one word before the partial word is dropped.
- `div_clk`  input  1  sampling clock, 16× baud.
- `reset`  input  1  reset, synchronous, active-high.
- `rx`  input  1  asynchronous serial line; idle high.
- `data`  output  32  last completed word; first byte received in [7:0], fourth byte in [31:24].
- `data_valid`  output  1  one-cycle pulse when `data` is updated.
- `frame_err`  output  1  one-cycle pulse on a bad stop bit.
- `busy`  output  1  high while a byte is in progress or a partial word is held.

## Operation
- Input sync: two-flop synchronizer on `rx`. All decisions use the synchronized bit `rxs`. Both flops reset to 1.
- Counters:
  - tick counter `tick`: 0..OVERSAMPLE-1.
  - bit counter `bitn`: 3 bits.
  - byte counter `byten`: 2 bits.
  - timeout counter: counts ticks up to TIMEOUT_BITS·OVERSAMPLE.
  - shift register: 8 bits.
  - word assembly register: 24 bits, holding bytes 0–2.
- FSM states:
  - **IDLE**: `tick`=0. On `rxs`=0, go to START.
  - **START**: `tick` increments each cycle. At `tick`=OVERSAMPLE/2−1 (mid start bit):
    - if `rxs`=0: reset `tick`, set `bitn`=0, go to DATA;
    - else: false start, return to IDLE. The partial word is kept.
  - **DATA**: at each `tick`=OVERSAMPLE−1, reset `tick` and shift `rxs` into the shift register MSB. Shifting right makes the byte LSB-first. After `bitn`=7 is sampled, go to STOP.
  - **STOP**: at `tick`=OVERSAMPLE−1, sample the stop bit.
    - If `rxs`=1, the byte is accepted:
      - for `byten`<3, store the byte in lane `byten`, increment `byten`, go to IDLE;
      - for `byten`=3, load `data` = {byte, lanes 2..0}, pulse `data_valid`, clear `byten`, go to IDLE.
    - If `rxs`=0: pulse `frame_err`, clear `byten` to drop the partial word, go to BREAK.
  - **BREAK**: wait for `rxs`=1, then go to IDLE. This stops a held-low line from generating repeated false starts.
- Timeout:
  - The timeout counter runs only in IDLE while `byten`≠0. It clears whenever the FSM leaves IDLE.
  - When it reaches TIMEOUT_BITS·OVERSAMPLE, `byten` clears. No pulse is produced.
- `data` holds its value until the next completed word. It is never cleared except by reset.
- `busy` = (state≠IDLE) or (`byten`≠0).

## Timing
- Reset values:
  - `data`=0, `data_valid`=0, `frame_err`=0, `busy`=0;
  - state IDLE, all counters 0, synchronizer flops 1.
- `reset` has priority over all other activity. Asserting it mid-byte or mid-word aborts the transfer and drops partial data with no pulse.
- Latency from a `rx` falling edge to START: 2 cycles through the synchronizer, plus 1 cycle.
- Sample points:
  - start bit: OVERSAMPLE/2 cycles after entering START;
  - each later bit: OVERSAMPLE cycles after the previous sample.
- `data_valid` and `frame_err` are registered. Each is high exactly one cycle, in the cycle after the stop-bit sample. They are never high together.
- Back-to-back bytes need no extra idle time. The FSM re-enters IDLE at mid stop bit, so it can catch a start edge that immediately follows.
- Consumers must sample `data` in the cycle `data_valid`=1 or later. `data` is stable from that cycle until the next `data_valid`.

## Test plan
- Word 0x00000001: send bytes 01 00 00 00 at 16 ticks/bit, no gaps. Required: exactly one `data_valid`, with `data`=0x00000001, and `busy`=0 afterward.
- Word 0xDEADBEEF: send bytes EF BE AD DE with 3-bit idle gaps. Required: `data`=0xDEADBEEF, `data_valid` high for 1 cycle.
- Framing error: send byte 0x55 with the stop bit low, then the line high, then bytes 02 00 00 00. Required: one `frame_err` pulse, no `data_valid` for the corrupted attempt, then `data`=0x00000002.
- Glitch: hold `rx` low for 5 cycles. Required: return to IDLE, no pulses, `byten` unchanged.
- Timeout: send byte AA, idle 41 bit periods, then send 03 00 00 00. Required: the first byte is discarded and `data`=0x00000003, not containing 0xAA.
- Reset mid-word: send 2 bytes, assert `reset` during the third byte's data bits, then send 04 00 00 00. Required: all outputs are 0 during reset, then `data`=0x00000004.
